mem_dpram_burst_ctrl: RTL

//  Burst sequencer for the simple dual-port sync RAM: accepts one read or write burst command, then generates
//  per-beat RAM write/read strobes and addresses. Streams write data in and read data out via valid/ready.

---
 rtl/mem_dpram_burst_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_dpram_burst_ctrl.sv
// Burst sequencer for a simple dual-port sync RAM: one read or write burst per command.
// Define MEM_DPRAM_CTRL_WRAP_EN to add the CMD_WRAP input (wrapping bursts).
module mem_dpram_burst_ctrl #(
  parameter int unsigned WIDTH_AD   = 10,
  parameter int unsigned WIDTH_DA   = 32,
  parameter int unsigned WIDTH_LEN  = 8,
  localparam int unsigned WIDTH_DS  = WIDTH_DA / 8,
  localparam int unsigned WIDTH_DSB = $clog2(WIDTH_DS)
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic                 CMD_WRITE,
  input  logic [WIDTH_AD-1:0]  CMD_ADDR,
  input  logic [WIDTH_LEN-1:0] CMD_LEN,
`ifdef MEM_DPRAM_CTRL_WRAP_EN
  input  logic                 CMD_WRAP,
`endif
  input  logic [WIDTH_DA-1:0]  WR_DATA,
  input  logic [WIDTH_DS-1:0]  WR_STRB,
  input  logic                 WR_VALID,
  output logic                 WR_READY,
  output logic [WIDTH_DA-1:0]  RD_DATA,
  output logic                 RD_VALID,
  input  logic                 RD_READY,
  output logic                 RD_LAST,
  output logic [WIDTH_AD-1:0]  MEM_WADDR,
  output logic [WIDTH_DA-1:0]  MEM_WDATA,
  output logic [WIDTH_DS-1:0]  MEM_WSTRB,
  output logic                 MEM_WEN,
  output logic [WIDTH_AD-1:0]  MEM_RADDR,
  output logic                 MEM_REN,
  input  logic [WIDTH_DA-1:0]  MEM_RDATA
);

  typedef enum logic [1:0] {StIdle, StWr, StRd} state_e;

  localparam logic [WIDTH_AD-1:0]  AddrStep = WIDTH_AD'(1 << WIDTH_DSB);
  localparam logic [WIDTH_AD-1:0]  LsbMask  = WIDTH_AD'((1 << WIDTH_DSB) - 1);
  localparam logic [WIDTH_LEN:0]   BeatOne  = {{WIDTH_LEN{1'b0}}, 1'b1};

  state_e               state_q;
  logic [WIDTH_AD-1:0]  addr_q;
  logic [WIDTH_AD-1:0]  addr_inc;
  logic [WIDTH_LEN:0]   beats_q;
  logic                 infl_q;
  logic                 infl_last_q;
  logic [WIDTH_DA-1:0]  fifo_data_q [2];
  logic [WIDTH_DA-1:0]  fifo_data_d [2];
  logic [1:0]           fifo_last_q;
  logic [1:0]           fifo_last_d;
  logic [1:0]           fifo_cnt_q;
  logic [1:0]           fifo_cnt_d;
  logic [1:0]           fifo_cnt_pop;
  logic [1:0]           occ;
  logic                 wr_hs;
  logic                 rd_pop;
  logic                 ren;
  logic                 last_issue;

`ifdef MEM_DPRAM_CTRL_WRAP_EN
  localparam logic [WIDTH_AD-1:0] AddrOne = {{(WIDTH_AD-1){1'b0}}, 1'b1};

  logic [WIDTH_AD-1:0] wmask_q;
  logic [WIDTH_AD-1:0] wmask_cmd;
  logic [WIDTH_AD-1:0] len_ad;

  // All-ones mask means plain incrementing; a window mask keeps the upper bits fixed.
  always_comb begin
    len_ad    = WIDTH_AD'(CMD_LEN);
    wmask_cmd = '1;
    if (CMD_WRAP && (len_ad == WIDTH_AD'(1) || len_ad == WIDTH_AD'(3) ||
                     len_ad == WIDTH_AD'(7) || len_ad == WIDTH_AD'(15))) begin
      wmask_cmd = ((len_ad + AddrOne) << WIDTH_DSB) - AddrOne;
    end
  end

  assign addr_inc = (addr_q & ~wmask_q) | ((addr_q + AddrStep) & wmask_q);
`else
  assign addr_inc = addr_q + AddrStep;
`endif

  assign CMD_READY  = (state_q == StIdle);
  assign WR_READY   = (state_q == StWr);
  assign wr_hs      = WR_VALID && WR_READY;
  assign MEM_WEN    = wr_hs;
  assign MEM_WADDR  = addr_q;
  assign MEM_WDATA  = WR_DATA;
  assign MEM_WSTRB  = WR_STRB;
  assign MEM_RADDR  = addr_q;

  assign RD_VALID   = (fifo_cnt_q != 2'd0);
  assign RD_DATA    = fifo_data_q[0];
  assign RD_LAST    = RD_VALID && fifo_last_q[0];
  assign rd_pop     = RD_VALID && RD_READY;
  assign last_issue = (beats_q == BeatOne);

  // Credit counts the head beat leaving this cycle so a steady stream runs at one beat/clk.
  assign fifo_cnt_pop = fifo_cnt_q - {1'b0, rd_pop};
  assign occ          = fifo_cnt_pop + {1'b0, infl_q};
  assign ren          = (state_q == StRd) && (beats_q != '0) && (occ < 2'd2);
  assign MEM_REN      = ren;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      beats_q     <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
`ifdef MEM_DPRAM_CTRL_WRAP_EN
      wmask_q     <= '1;
`endif
    end else begin
      infl_q      <= ren;
      infl_last_q <= ren && last_issue;
      case (state_q)
        StIdle: begin
          if (CMD_VALID) begin
            addr_q  <= CMD_ADDR & ~LsbMask;
            beats_q <= {1'b0, CMD_LEN} + BeatOne;
`ifdef MEM_DPRAM_CTRL_WRAP_EN
            wmask_q <= wmask_cmd;
`endif
            state_q <= CMD_WRITE ? StWr : StRd;
          end
        end
        StWr: begin
          if (wr_hs) begin
            addr_q  <= addr_inc;
            beats_q <= beats_q - BeatOne;
            if (last_issue) state_q <= StIdle;
          end
        end
        StRd: begin
          if (ren) begin
            addr_q  <= addr_inc;
            beats_q <= beats_q - BeatOne;
          end
          if (rd_pop && RD_LAST) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Two-entry skid buffer, head always in slot 0.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (rd_pop) begin
      fifo_data_d[0] = fifo_data_q[1];
      fifo_last_d[0] = fifo_last_q[1];
    end
    if (infl_q) begin
      fifo_data_d[fifo_cnt_pop[0]] = MEM_RDATA;
      fifo_last_d[fifo_cnt_pop[0]] = infl_last_q;
    end
    fifo_cnt_d = fifo_cnt_pop + {1'b0, infl_q};
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      fifo_cnt_q     <= '0;
    end else begin
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

endmodule
